multicore_ram_port_arbiter: RTL and testbench
=============================================

Name: multicore_ram_port_arbiter

Overview:
- Round-robin arbiter sharing one port of the dual-port on-chip program/data RAM between NUM_MASTERS Nios II core data masters.
- Sits between the cores' Avalon-MM masters and the RAM's s1/s2 slave signals (address, byteenable, chipselect, write, writedata, clken, readdata).
- Grants one transfer per cycle, stalls losers with waitrequest, and returns read data with a readdatavalid tag matching the RAM's 1-cycle read latency.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- ADDR_W, 12, word address width (4096 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m_read  in  NUM_MASTERS  per-master read request.
- m_write  in  NUM_MASTERS  per-master write request.
- m_address  in  NUM_MASTERS*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W].
- m_byteenable  in  NUM_MASTERS*BE_W  packed per master.
- m_writedata  in  NUM_MASTERS*DATA_W  packed per master.
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- m_readdatavalid  out  NUM_MASTERS  per-master read-data strobe.
- m_readdata  out  DATA_W  shared read data bus, valid for master with readdatavalid high.
- mem_address  out  ADDR_W  to RAM port address.
- mem_byteenable  out  BE_W  to RAM port byteenable.
- mem_chipselect  out  1  to RAM port chipselect.
- mem_write  out  1  to RAM port write.
- mem_writedata  out  DATA_W  to RAM port writedata.
- mem_clken  out  1  to RAM port clken; tied high.
- mem_readdata  in  DATA_W  from RAM port readdata.

Behaviour:
- Request: req[i] = m_read[i] | m_write[i]. If both are high, the request is treated as a write.
- Arbitration is combinational in the same cycle. The search starts at (last_grant+1) mod NUM_MASTERS and wraps. The first requester found is granted.
- last_grant resets to NUM_MASTERS-1, so master 0 has top priority after reset. last_grant updates only on cycles with a grant.
- Granted master: m_waitrequest low. All other requesters: waitrequest high. Non-requesters: waitrequest high (don't-care to masters).
- Memory drive:
  - With a grant: mem_chipselect=1; mem_write = granted write; address, byteenable and writedata muxed from the winner.
  - Idle: chipselect=0, write=0, address/byteenable/writedata hold the master-0 values.
- Read pipeline:
  - On a granted read, register rd_pend=1 and rd_idx=winner.
  - The next cycle drives m_readdatavalid[rd_idx]=1 and m_readdata=mem_readdata.
  - Latency is exactly 1 cycle from grant edge to readdatavalid.
  - Back-to-back reads from different masters pipeline fully: one read per cycle, readdatavalid one per cycle in grant order.
- Writes: complete on the grant cycle; no response.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,...,N-1,0. Each master waits at most NUM_MASTERS-1 cycles.
- Reset mid-operation: asynchronous clear of rd_pend, rd_idx and last_grant. m_readdatavalid is all-zero immediately, and any in-flight read is dropped.
- Output values under reset: m_readdatavalid=0, m_readdata=0, mem_chipselect=0, mem_write=0, m_waitrequest=all ones.
- m_readdata is registered mem_readdata gated by rd_pend; it is 0 when no read is returning.

Optional Feature:
- Macro: MULTICORE_ARB_LOCK_EN.
- With the macro: adds input m_lock [NUM_MASTERS].
  - A granted master asserting m_lock keeps the grant on subsequent cycles regardless of other requests, until it deasserts m_lock or drops its request.
  - last_grant is not advanced while locked.
  - Used for read-modify-write mutex sequences.
- Without the macro: the port is absent and arbitration is pure round-robin.

Test Plan:
- Reset release, no requests -> m_waitrequest=4'b1111, mem_chipselect=0, m_readdatavalid=0.
- Master 2 reads address 0x010 holding 0xDEADBEEF -> grant that cycle; next cycle m_readdatavalid=4'b0100, m_readdata=0xDEADBEEF.
- All 4 masters request reads continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; readdatavalid one-hot in the same order, one cycle delayed.
- Master 1 writes 0x12345678 to 0x0FF with byteenable=4'b0011 while master 3 reads 0x0FF -> master 1 granted first; master 3 read next cycle returns 0x00005678 in the low half (high half unchanged).
- Assert reset_n low the cycle after a granted read -> m_readdatavalid stays 0; after release, master 0 wins first.
- With MULTICORE_ARB_LOCK_EN: master 0 holds m_lock for 3 write cycles while masters 1..3 request -> three consecutive master-0 grants, then master 1 is granted.

Source files
------------

// File: rtl/multicore_ram_port_arbiter.sv
// rtl/multicore_ram_port_arbiter.sv - round-robin arbiter sharing one on-chip RAM port between core data masters.
// Optional master lock (m_lock) is built when MULTICORE_ARB_LOCK_EN is defined.
module multicore_ram_port_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int BE_W        = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
   input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
`ifdef MULTICORE_ARB_LOCK_EN
   input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
   output logic [NUM_MASTERS-1:0]        m_waitrequest,
   output logic [NUM_MASTERS-1:0]        m_readdatavalid,
   output logic [DATA_W-1:0]             m_readdata,
   output logic [ADDR_W-1:0]             mem_address,
   output logic [BE_W-1:0]               mem_byteenable,
   output logic                          mem_chipselect,
   output logic                          mem_write,
   output logic [DATA_W-1:0]             mem_writedata,
   output logic                          mem_clken,
   input  logic [DATA_W-1:0]             mem_readdata
);

   localparam int                IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IDX_W:0]    NUM_M    = (IDX_W+1)'(NUM_MASTERS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS-1);

   logic [NUM_MASTERS-1:0] req;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic                   rd_pend_q, rd_pend_d;
   logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
   logic                   grant_valid;
   logic                   hold_grant;
   logic [IDX_W-1:0]       grant_idx;
   logic [IDX_W:0]         cand;
   logic [IDX_W-1:0]       sel_idx;

   assign req = m_read | m_write;

`ifdef MULTICORE_ARB_LOCK_EN
   logic lock_active_q, lock_active_d;

   // The lock owner is always last_grant_q, since held grants never advance it.
   assign hold_grant = lock_active_q & req[last_grant_q];

   always_comb begin
      lock_active_d = grant_valid & m_lock[grant_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_active_q <= 1'b0;
      end else begin
         lock_active_q <= lock_active_d;
      end
   end
`else
   assign hold_grant = 1'b0;
`endif

   // Scan from the farthest candidate back to last_grant+1 so the nearest requester wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (hold_grant) begin
         grant_valid = 1'b1;
         grant_idx   = last_grant_q;
      end else begin
         for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            if (cand >= NUM_M) begin
               cand = cand - NUM_M;
            end
            if (req[cand[IDX_W-1:0]]) begin
               grant_valid = 1'b1;
               grant_idx   = cand[IDX_W-1:0];
            end
         end
      end
      if (!reset_n) begin
         grant_valid = 1'b0;
      end
   end

   assign sel_idx        = grant_valid ? grant_idx : '0;
   assign mem_address    = m_address[int'(sel_idx)*ADDR_W +: ADDR_W];
   assign mem_byteenable = m_byteenable[int'(sel_idx)*BE_W +: BE_W];
   assign mem_writedata  = m_writedata[int'(sel_idx)*DATA_W +: DATA_W];
   assign mem_chipselect = grant_valid;
   assign mem_write      = grant_valid & m_write[grant_idx];
   assign mem_clken      = 1'b1;

   always_comb begin
      m_waitrequest = '1;
      if (grant_valid) begin
         m_waitrequest[grant_idx] = 1'b0;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      rd_pend_d    = grant_valid & ~m_write[grant_idx];
      rd_idx_d     = rd_idx_q;
      if (grant_valid && !hold_grant) begin
         last_grant_d = grant_idx;
      end
      if (rd_pend_d) begin
         rd_idx_d = grant_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= LAST_IDX;
         rd_pend_q    <= 1'b0;
         rd_idx_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_pend_q    <= rd_pend_d;
         rd_idx_q     <= rd_idx_d;
      end
   end

   // The RAM's registered output lines up with rd_pend_q one cycle after the grant.
   always_comb begin
      m_readdatavalid = '0;
      if (rd_pend_q) begin
         m_readdatavalid[rd_idx_q] = 1'b1;
      end
   end

   assign m_readdata = rd_pend_q ? mem_readdata : '0;

endmodule

// File: tb/tb_multicore_ram_port_arbiter.sv
// tb/tb_multicore_ram_port_arbiter.sv - directed self-checking bench for multicore_ram_port_arbiter.
module tb_multicore_ram_port_arbiter;

   localparam int NM = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = 4;

   logic             clk;
   logic             reset_n;
   logic [NM-1:0]    m_read;
   logic [NM-1:0]    m_write;
   logic [NM*AW-1:0] m_address;
   logic [NM*BW-1:0] m_byteenable;
   logic [NM*DW-1:0] m_writedata;
   logic [NM-1:0]    m_lock;
   logic [NM-1:0]    m_waitrequest;
   logic [NM-1:0]    m_readdatavalid;
   logic [DW-1:0]    m_readdata;
   logic [AW-1:0]    mem_address;
   logic [BW-1:0]    mem_byteenable;
   logic             mem_chipselect;
   logic             mem_write;
   logic [DW-1:0]    mem_writedata;
   logic             mem_clken;
   logic [DW-1:0]    mem_readdata;

   int checks;
   int failures;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   multicore_ram_port_arbiter #(
      .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .m_read         (m_read),
      .m_write        (m_write),
      .m_address      (m_address),
      .m_byteenable   (m_byteenable),
      .m_writedata    (m_writedata),
`ifdef MULTICORE_ARB_LOCK_EN
      .m_lock         (m_lock),
`endif
      .m_waitrequest  (m_waitrequest),
      .m_readdatavalid(m_readdatavalid),
      .m_readdata     (m_readdata),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM port model: byte-enabled write, one-cycle registered read, plus a backdoor preload.
   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_addr] <= bd_data;
      end else if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < BW; b++) begin
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_read       = '0;
      m_write      = '0;
      m_lock       = '0;
      m_address    = '0;
      m_byteenable = '1;
      m_writedata  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      cyc();
      bd_we   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1111) begin failures++; $display("FAIL reset_waitrequest got=%b exp=%b", m_waitrequest, 4'b1111); end
      checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("FAIL reset_chipselect got=%b exp=0", mem_chipselect); end
      checks++; if (m_readdatavalid !== 4'b0000) begin failures++; $display("FAIL reset_rdvalid got=%b exp=0000", m_readdatavalid); end
      checks++; if (m_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", m_readdata); end
      checks++; if (mem_write !== 1'b0 || mem_clken !== 1'b1) begin failures++; $display("FAIL reset_write_clken got=%b%b exp=01", mem_write, mem_clken); end
      cyc();
   endtask

   task automatic test_single_read();
      do_reset();
      poke(12'h010, 32'hDEADBEEF);
      m_address[0*AW +: AW] = 12'h123;
      m_address[2*AW +: AW] = 12'h010;
      m_read[2] = 1'b1;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1011) begin failures++; $display("FAIL single_grant got=%b exp=1011", m_waitrequest); end
      checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL single_cs_wr got=%b%b exp=10", mem_chipselect, mem_write); end
      checks++; if (mem_address !== 12'h010) begin failures++; $display("FAIL single_addr got=%h exp=010", mem_address); end
      checks++; if (m_readdatavalid !== 4'b0000) begin failures++; $display("FAIL single_early_valid got=%b exp=0000", m_readdatavalid); end
      cyc();
      m_read = '0;
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b0100) begin failures++; $display("FAIL single_valid got=%b exp=0100", m_readdatavalid); end
      checks++; if (m_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", m_readdata); end
      checks++; if (mem_chipselect !== 1'b0 || mem_address !== 12'h123) begin failures++; $display("FAIL idle_drive got=%b/%h exp=0/123", mem_chipselect, mem_address); end
      cyc();
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b0000 || m_readdata !== 32'h0) begin failures++; $display("FAIL single_after got=%b/%h exp=0000/0", m_readdatavalid, m_readdata); end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp_wr;
      logic [NM-1:0] exp_v;
      int            g;
      int            p;
      do_reset();
      for (int i = 0; i < NM; i++) poke(12'h020 + 12'(i), 32'hA0A00000 + 32'(i));
      for (int i = 0; i < NM; i++) m_address[i*AW +: AW] = 12'h020 + 12'(i);
      m_read = '1;
      for (int c = 0; c < 8; c++) begin
         g = c % NM;
         exp_wr = '1;
         exp_wr[g] = 1'b0;
         @(negedge clk);
         checks++; if (m_waitrequest !== exp_wr) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, m_waitrequest, exp_wr); end
         checks++; if (mem_address !== 12'h020 + 12'(g)) begin failures++; $display("FAIL rr_addr c=%0d got=%h exp=%h", c, mem_address, 12'h020 + 12'(g)); end
         if (c > 0) begin
            p = (c - 1) % NM;
            exp_v = '0;
            exp_v[p] = 1'b1;
            checks++; if (m_readdatavalid !== exp_v || m_readdata !== 32'hA0A00000 + 32'(p)) begin failures++; $display("FAIL rr_rdata c=%0d got=%b/%h exp=%b/%h", c, m_readdatavalid, m_readdata, exp_v, 32'hA0A00000 + 32'(p)); end
         end
         cyc();
      end
      m_read = '0;
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b1000 || m_readdata !== 32'hA0A00003) begin failures++; $display("FAIL rr_last got=%b/%h exp=1000/a0a00003", m_readdatavalid, m_readdata); end
      cyc();
   endtask

   task automatic test_write_then_read();
      do_reset();
      poke(12'h0FF, 32'h9ABC0000);
      m_address[1*AW +: AW]     = 12'h0FF;
      m_byteenable[1*BW +: BW]  = 4'b0011;
      m_writedata[1*DW +: DW]   = 32'h12345678;
      m_write[1] = 1'b1;
      m_address[3*AW +: AW]     = 12'h0FF;
      m_read[3] = 1'b1;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1101 || mem_write !== 1'b1) begin failures++; $display("FAIL wr_grant got=%b/%b exp=1101/1", m_waitrequest, mem_write); end
      checks++; if (mem_byteenable !== 4'b0011 || mem_writedata !== 32'h12345678) begin failures++; $display("FAIL wr_mux got=%b/%h exp=0011/12345678", mem_byteenable, mem_writedata); end
      cyc();
      m_write = '0;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b0111 || mem_write !== 1'b0) begin failures++; $display("FAIL rd_after_wr_grant got=%b/%b exp=0111/0", m_waitrequest, mem_write); end
      checks++; if (m_readdatavalid !== 4'b0000) begin failures++; $display("FAIL wr_no_response got=%b exp=0000", m_readdatavalid); end
      cyc();
      m_read = '0;
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b1000 || m_readdata !== 32'h9ABC5678) begin failures++; $display("FAIL rmw_data got=%b/%h exp=1000/9abc5678", m_readdatavalid, m_readdata); end
      cyc();
   endtask

   task automatic test_read_and_write();
      do_reset();
      m_address[2*AW +: AW]    = 12'h300;
      m_writedata[2*DW +: DW]  = 32'h0BADF00D;
      m_read[2]  = 1'b1;
      m_write[2] = 1'b1;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1011 || mem_write !== 1'b1) begin failures++; $display("FAIL both_is_write got=%b/%b exp=1011/1", m_waitrequest, mem_write); end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b0000) begin failures++; $display("FAIL both_no_valid got=%b exp=0000", m_readdatavalid); end
      cyc();
   endtask

   task automatic test_reset_mid();
      do_reset();
      poke(12'h040, 32'h55AA55AA);
      m_address[1*AW +: AW] = 12'h040;
      m_read[1] = 1'b1;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1101) begin failures++; $display("FAIL mid_grant got=%b exp=1101", m_waitrequest); end
      cyc();
      reset_n = 1'b0;
      m_read  = '1;
      @(negedge clk);
      checks++; if (m_readdatavalid !== 4'b0000 || m_readdata !== 32'h0) begin failures++; $display("FAIL mid_dropped got=%b/%h exp=0000/0", m_readdatavalid, m_readdata); end
      checks++; if (m_waitrequest !== 4'b1111 || mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL mid_in_reset got=%b/%b/%b exp=1111/0/0", m_waitrequest, mem_chipselect, mem_write); end
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1110 || m_readdatavalid !== 4'b0000) begin failures++; $display("FAIL mid_release got=%b/%b exp=1110/0000", m_waitrequest, m_readdatavalid); end
      cyc();
      clear_inputs();
      cyc();
   endtask

`ifdef MULTICORE_ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      for (int i = 0; i < NM; i++) m_address[i*AW +: AW] = 12'h200 + 12'(i);
      m_write = 4'b0001;
      m_lock  = 4'b0001;
      m_read  = 4'b1110;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (m_waitrequest !== 4'b1110) begin failures++; $display("FAIL lock_hold c=%0d got=%b exp=1110", c, m_waitrequest); end
         cyc();
      end
      m_write = '0;
      m_lock  = '0;
      @(negedge clk);
      checks++; if (m_waitrequest !== 4'b1101) begin failures++; $display("FAIL lock_release got=%b exp=1101", m_waitrequest); end
      cyc();
      clear_inputs();
      cyc();
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      bd_we    = 1'b0;
      bd_addr  = '0;
      bd_data  = '0;
      clear_inputs();
      reset_n  = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_then_read();
      test_read_and_write();
      test_reset_mid();
`ifdef MULTICORE_ARB_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
